// File: rtl/rfphoenix_mcvalu_sched_pkg.sv
// Shared types for the multi-cycle vector ALU scheduler.
//   instruction_t  : instruction word handed to the ALU
//   tid_t          : thread id carried with each operation
//   pipeline_reg_t : operation payload (instruction + operand data)
//   sched_state_t  : scheduler FSM states
package rfphoenix_mcvalu_sched_pkg;

  typedef logic [31:0] instruction_t;
  typedef logic [3:0]  tid_t;

  typedef struct packed {
    instruction_t ir;
    logic [31:0]  data;
  } pipeline_reg_t;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_ISSUE = 2'd1,
    SCHED_WAIT  = 2'd2,
    SCHED_RESP  = 2'd3
  } sched_state_t;

  // Width of the WAIT-state watchdog counter.
  localparam int WAIT_CNT_W = 6;

endpackage

// File: rtl/rfphoenix_mcvalu_sched_rrarb.sv
// Combinational round-robin picker.
//   req : per-requester request level
//   rr  : index of the highest-priority requester this round
//   win : one-hot winner
//   idx : binary index of the winner
//   any : at least one request present
module rfphoenix_mcvalu_sched_rrarb #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   rr,
  output logic [NREQ-1:0] win,
  output logic [IW-1:0]   idx,
  output logic            any
);

  localparam logic [IW:0] NREQ_W = (IW+1)'(NREQ);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          hit;

  // Scan requesters starting at rr, wrapping modulo NREQ; first requester found wins.
  always_comb begin
    win  = '0;
    idx  = '0;
    any  = 1'b0;
    sum  = '0;
    cand = '0;
    hit  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      sum       = {1'b0, rr} + (IW+1)'(i);
      cand      = (sum >= NREQ_W) ? IW'(sum - NREQ_W) : IW'(sum);
      hit       = req[cand] & ~any;
      win[cand] = win[cand] | hit;
      idx       = hit ? cand : idx;
      any       = any | req[cand];
    end
  end

endmodule

// File: rtl/rfphoenix_mcvalu_sched.sv
// Scheduler for a shared multi-cycle vector ALU. Requesters are served one at
// a time in round-robin order: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// Optional feature macro: MCVALU_SCHED_TIMEOUT_EN adds a WAIT-state watchdog
// that ends the operation with rsp_tmo=1 after TIMEOUT cycles.
// Ports:
//   clk, rst (async, active-low)
//   req/req_pr/req_tid : per-requester request, payload, thread id
//   gnt                : one-hot grant pulse (payload consumed)
//   alu_go/alu_ir/alu_i: ALU start pulse, instruction and payload
//   alu_done/alu_o     : ALU completion and result
//   rsp_v/rsp_tid/rsp_o/rsp_tmo, rsp_rdy : response handshake
//   busy               : FSM not in IDLE
module rfphoenix_mcvalu_sched
  import rfphoenix_mcvalu_sched_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 63
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  pipeline_reg_t [NREQ-1:0] req_pr,
  input  tid_t [NREQ-1:0]          req_tid,
  output logic [NREQ-1:0]          gnt,
  output logic                     alu_go,
  output instruction_t             alu_ir,
  output pipeline_reg_t            alu_i,
  input  logic                     alu_done,
  input  pipeline_reg_t            alu_o,
  output logic                     rsp_v,
  output tid_t                     rsp_tid,
  output pipeline_reg_t            rsp_o,
  output logic                     rsp_tmo,
  input  logic                     rsp_rdy,
  output logic                     busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  sched_state_t  state;
  logic [IW-1:0] rr;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] rr_next;
  pipeline_reg_t pl;
  tid_t          tid_l;

  logic [NREQ-1:0] arb_win;
  logic [IW-1:0]   arb_idx;
  logic            arb_any;

  rfphoenix_mcvalu_sched_rrarb #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rrarb (
    .req (req),
    .rr  (rr),
    .win (arb_win),
    .idx (arb_idx),
    .any (arb_any)
  );

  // Next round-robin pointer: one past the winner, wrapping to 0.
  assign rr_next = (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);

  // The latched payload drives the ALU for the whole operation.
  assign alu_i  = pl;
  assign alu_ir = pl.ir;

`ifdef MCVALU_SCHED_TIMEOUT_EN
  localparam logic [WAIT_CNT_W-1:0] TMO_LIMIT = WAIT_CNT_W'(TIMEOUT);
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic [WAIT_CNT_W-1:0] wait_cnt_nxt;
  logic                  tmo_flag;
  // wait_cnt counts completed WAIT cycles; the watchdog fires as it reaches TIMEOUT.
  assign wait_cnt_nxt = wait_cnt + WAIT_CNT_W'(1);
  assign rsp_tmo      = tmo_flag;
`else
  assign rsp_tmo = 1'b0;
`endif

  // Scheduler FSM with all handshake outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SCHED_IDLE;
      rr      <= '0;
      win_idx <= '0;
      pl      <= '0;
      tid_l   <= '0;
      gnt     <= '0;
      alu_go  <= 1'b0;
      rsp_v   <= 1'b0;
      rsp_tid <= '0;
      rsp_o   <= '0;
      busy    <= 1'b0;
`ifdef MCVALU_SCHED_TIMEOUT_EN
      wait_cnt <= '0;
      tmo_flag <= 1'b0;
`endif
    end else begin
      case (state)
        SCHED_IDLE: begin
          if (arb_any) begin
            win_idx <= arb_idx;
            pl      <= req_pr[arb_idx];
            tid_l   <= req_tid[arb_idx];
            gnt     <= arb_win;
            alu_go  <= 1'b1;
            busy    <= 1'b1;
            state   <= SCHED_ISSUE;
          end
        end
        SCHED_ISSUE: begin
          // alu_done is deliberately not looked at here: a done left over
          // from an earlier operation must not complete this one.
          gnt    <= '0;
          alu_go <= 1'b0;
          rr     <= rr_next;
          state  <= SCHED_WAIT;
`ifdef MCVALU_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        SCHED_WAIT: begin
          if (alu_done) begin
            rsp_o   <= alu_o;
            rsp_tid <= tid_l;
            rsp_v   <= 1'b1;
            state   <= SCHED_RESP;
`ifdef MCVALU_SCHED_TIMEOUT_EN
            tmo_flag <= 1'b0;
          end else if (wait_cnt_nxt == TMO_LIMIT) begin
            // Watchdog expiry returns the original payload flagged as timed out.
            rsp_o    <= pl;
            rsp_tid  <= tid_l;
            rsp_v    <= 1'b1;
            tmo_flag <= 1'b1;
            wait_cnt <= wait_cnt_nxt;
            state    <= SCHED_RESP;
          end else begin
            wait_cnt <= wait_cnt_nxt;
`endif
          end
        end
        SCHED_RESP: begin
          if (rsp_rdy) begin
            rsp_v <= 1'b0;
            busy  <= 1'b0;
            state <= SCHED_IDLE;
`ifdef MCVALU_SCHED_TIMEOUT_EN
            tmo_flag <= 1'b0;
`endif
          end
        end
        default: begin
          gnt    <= '0;
          alu_go <= 1'b0;
          rsp_v  <= 1'b0;
          busy   <= 1'b0;
          state  <= SCHED_IDLE;
        end
      endcase
    end
  end

endmodule
